uart_receiver: RTL



---
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: 16x-oversampled UART receive stage (5-8 data bits, parity, one stop bit, loopback).
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority voting per bit. Rev 1.0
module uart_receiver (
    input  logic       pclk,
    input  logic       preset,
    input  logic       urrst,
    input  logic       receive_edge,
    input  logic       uart_rxd,
    input  logic       loop_txd,
    input  logic       loop,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Majority voting decides one tick later, so the counter is reloaded to keep a 16-tick pitch.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] START_PT     = 4'd8;
    localparam logic [3:0] BIT_PT       = 4'd0;
    localparam logic [3:0] START_RELOAD = 4'd1;
`else
    localparam logic [3:0] START_PT     = 4'd7;
    localparam logic [3:0] BIT_PT       = 4'd15;
    localparam logic [3:0] START_RELOAD = 4'd0;
`endif

    state_t     state;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] shift;
    logic       rxd_meta;
    logic       rxd_sync;
    logic       rxd_prev;
    logic       line;
    logic       bit_val;
    logic       par_bit;
    logic       par_err;
    logic [7:0] mask;
    logic [7:0] data_m;
    logic       exp_par;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    assign line = loop ? loop_txd : rxd_sync;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            hist <= 2'b11;
        end else if (receive_edge) begin
            hist <= {hist[0], line};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
`else
    assign bit_val = line;
`endif

    always_comb begin
        mask = 8'hFF;
        case (wls)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
    end

    assign data_m = shift & mask;

    always_comb begin
        exp_par = 1'b0;
        case ({sp, eps})
            2'b00:   exp_par = ~(^data_m);
            2'b01:   exp_par = ^data_m;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    assign rx_busy = (state != IDLE);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            scnt     <= 4'd0;
            bcnt     <= 3'd0;
            shift    <= 8'd0;
            rxd_prev <= 1'b1;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (urrst) begin
                state <= IDLE;
                scnt  <= 4'd0;
                bcnt  <= 3'd0;
            end else if (receive_edge) begin
                rxd_prev <= line;
                scnt     <= scnt + 4'd1;
                case (state)
                    IDLE: begin
                        if (rxd_prev && !line) begin
                            state <= START;
                            scnt  <= 4'd0;
                        end
                    end
                    START: begin
                        if (scnt == START_PT) begin
                            if (!bit_val) begin
                                state <= DATA;
                                scnt  <= START_RELOAD;
                                bcnt  <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (scnt == BIT_PT) begin
                            shift[bcnt] <= bit_val;
                            bcnt        <= bcnt + 3'd1;
                            if (bcnt == ({1'b0, wls} + 3'd4)) begin
                                state <= pen ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (scnt == BIT_PT) begin
                            par_bit <= bit_val;
                            par_err <= (bit_val != exp_par);
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (scnt == BIT_PT) begin
                            rx_data  <= data_m;
                            fe       <= ~bit_val;
                            pe       <= pen & par_err;
                            bi       <= (data_m == 8'd0) && !bit_val && (!pen || !par_bit);
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
